// File: rtl/pentarv_pkg.sv
// rtl/pentarv_pkg.sv - shared core widths and fetch constants
//
// Purpose: constants shared by the fetch front end.
//   XLEN      : address / PC width
//   ILEN      : instruction width
//   NOP_INSTR : addi x0,x0,0, presented when no instruction is available
//   PC_INC    : sequential fetch stride in bytes
package pentarv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular queue holding prefetched {pc, instr} entries
//
// Purpose: DEPTH-entry FIFO with flush. Storage has no reset; only the
// pointers and the occupancy count are reset.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write wdata at the tail (caller never pushes into a full
//               queue unless it pops in the same cycle)
//   pop       : drop the head (caller never pops an empty queue)
//   flush     : empty the queue; overrides push and pop
//   wdata     : entry to write
//   rdata     : entry at the head
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupied entries
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Storage is not reset: count alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - PC generation and prefetch queue for decode
//
// Purpose: fetches one instruction per cycle from a combinational
// instruction memory into a small queue feeding decode; redirects flush the
// queue and restart fetch at the new target.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   redirect_valid  : taken branch/jump; flush and load redirect_pc
//   redirect_pc     : redirect target (used as given, no alignment check)
//   imem_addr       : fetch address (current PC)
//   imem_en         : a fetch happens this cycle
//   imem_rdata      : instruction at imem_addr, same cycle
//   out_valid       : head entry valid for decode
//   out_ready       : decode accepts the head
//   out_instr       : head instruction, NOP when not valid
//   out_pc          : head PC, 0 when not valid
//   count           : occupied queue entries
module fetch_prefetch_queue
  import pentarv_pkg::*;
#(
  parameter int              XLEN     = pentarv_pkg::XLEN,
  parameter int              ILEN     = pentarv_pkg::ILEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        imem_addr,
  output logic                   imem_en,
  input  logic [ILEN-1:0]        imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ILEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);

  logic [XLEN-1:0]      pc;
  logic                 fire;
  logic                 fetch;
  logic                 full;
  logic                 empty;
  logic [XLEN+ILEN-1:0] head;

  // Redirect hides the head in the same cycle so decode never consumes a
  // wrong-path instruction.
  assign out_valid = ~empty & ~redirect_valid;
  assign fire      = out_valid & out_ready;

  // A full queue can still fetch when the head leaves in the same cycle.
  // rst is included so no fetch is advertised while reset is held.
  assign fetch     = ~rst & ~redirect_valid & (~full | fire);

  assign imem_en   = fetch;
  assign imem_addr = pc;

  assign out_instr = out_valid ? head[ILEN-1:0]         : ILEN'(NOP_INSTR);
  assign out_pc    = out_valid ? head[XLEN+ILEN-1:ILEN] : '0;

  // PC increments wrap modulo 2^XLEN by plain truncation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (fetch) begin
      pc <= pc + XLEN'(PC_INC);
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN + ILEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (fire),
    .flush (redirect_valid),
    .wdata ({pc, imem_rdata}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue
module tb_fetch_prefetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  fetch_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_en        (imem_en),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  // Instruction memory: word at address a reads as a+1.
  assign imem_rdata = imem_addr + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t tbl[$];

  // Scoreboard model: queue of expected {pc, instr} entries plus model PC.
  logic [63:0] m_q[$];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic e_en, input logic [31:0] e_addr, input logic e_valid,
                     input logic [31:0] e_pc, input logic [2:0] e_cnt);
    vec_t v;
    v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_en = e_en; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  // Compare against the model, then advance the model across the next edge.
  task automatic sb_check();
    logic        m_valid;
    logic        m_fire;
    logic        m_fetch;
    logic [63:0] hd;
    if (rst) begin
      m_q.delete();
      m_pc = 32'h0;
    end
    m_valid = (m_q.size() != 0) && !redirect_valid && !rst;
    hd = m_valid ? m_q[0] : {32'h0, 32'h0000_0013};
    chk("sb_out_valid", 64'(out_valid), 64'(m_valid));
    chk("sb_out_pc",    64'(out_pc),    64'(hd[63:32]));
    chk("sb_out_instr", 64'(out_instr), 64'(hd[31:0]));
    chk("sb_count",     64'(count),     64'(m_q.size()));
    m_fire  = m_valid && out_ready;
    m_fetch = !rst && !redirect_valid && ((m_q.size() < 4) || m_fire);
    chk("sb_imem_en",   64'(imem_en),   64'(m_fetch));
    chk("sb_imem_addr", 64'(imem_addr), 64'(m_pc));
    if (!rst) begin
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc;
      end else begin
        if (m_fire) void'(m_q.pop_front());
        if (m_fetch) begin
          m_q.push_back({m_pc, m_pc + 32'd1});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(posedge clk);
    #1;
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(negedge clk);
    sb_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    m_pc = 32'h0;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;

    //   r  rv rpc            rdy en addr           val pc             cnt
    // streaming at full throughput
    add(1, 0, 32'h0,          1,  0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          1,  1, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          1,  1, 32'h4,          1, 32'h0,          1);
    add(0, 0, 32'h0,          1,  1, 32'h8,          1, 32'h4,          1);
    add(0, 0, 32'h0,          1,  1, 32'hC,          1, 32'h8,          1);
    // stalled decode fills the queue, then simultaneous pop and push
    add(1, 0, 32'h0,          0,  0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          0,  1, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          0,  1, 32'h4,          1, 32'h0,          1);
    add(0, 0, 32'h0,          0,  1, 32'h8,          1, 32'h0,          2);
    add(0, 0, 32'h0,          0,  1, 32'hC,          1, 32'h0,          3);
    add(0, 0, 32'h0,          0,  0, 32'h10,         1, 32'h0,          4);
    add(0, 0, 32'h0,          0,  0, 32'h10,         1, 32'h0,          4);
    add(0, 0, 32'h0,          1,  1, 32'h10,         1, 32'h0,          4);
    add(0, 0, 32'h0,          1,  1, 32'h14,         1, 32'h4,          4);
    // redirect with three entries queued
    add(1, 0, 32'h0,          0,  0, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          0,  1, 32'h0,          0, 32'h0,          0);
    add(0, 0, 32'h0,          0,  1, 32'h4,          1, 32'h0,          1);
    add(0, 0, 32'h0,          0,  1, 32'h8,          1, 32'h0,          2);
    add(0, 1, 32'h100,        1,  0, 32'hC,          0, 32'h0,          3);
    add(0, 0, 32'h0,          1,  1, 32'h100,        0, 32'h0,          0);
    add(0, 0, 32'h0,          1,  1, 32'h104,        1, 32'h100,        1);
    // PC wrap at the top of the address space
    add(0, 1, 32'hFFFF_FFFC,  1,  0, 32'h108,        0, 32'h0,          1);
    add(0, 0, 32'h0,          1,  1, 32'hFFFF_FFFC,  0, 32'h0,          0);
    add(0, 0, 32'h0,          1,  1, 32'h0,          1, 32'hFFFF_FFFC,  1);
    add(0, 0, 32'h0,          1,  1, 32'h4,          1, 32'h0,          1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk($sformatf("tbl%0d_imem_en", i),   64'(imem_en),   64'(tbl[i].e_en));
      chk($sformatf("tbl%0d_imem_addr", i), 64'(imem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_out_pc", i),    64'(out_pc),    64'(tbl[i].e_pc));
      chk($sformatf("tbl%0d_out_instr", i), 64'(out_instr),
          64'(tbl[i].e_valid ? tbl[i].e_pc + 32'd1 : 32'h0000_0013));
      chk($sformatf("tbl%0d_count", i),     64'(count),     64'(tbl[i].e_cnt));
    end

    // Reset pulsed with two entries queued: outputs clear immediately and
    // fetch restarts at 0 with nothing stale presented.
    drive(0, 0, 32'h0, 0);
    drive(0, 0, 32'h0, 0);
    chk("pre_rst_count", 64'(count), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_count", 64'(count),     64'd0);
    chk("rst_async_en",    64'(imem_en),   64'd0);
    chk("rst_async_instr", 64'(out_instr), 64'h13);
    @(negedge clk);
    sb_check();
    drive(0, 0, 32'h0, 1);
    chk("rst_restart_addr", 64'(imem_addr), 64'h0);
    drive(0, 0, 32'h0, 1);
    chk("rst_first_pc",    64'(out_pc),    64'h0);
    chk("rst_first_instr", 64'(out_instr), 64'h1);

    // Unaligned redirect target used as given.
    drive(0, 1, 32'h0000_0203, 1);
    drive(0, 0, 32'h0, 1);
    chk("unaligned_addr", 64'(imem_addr), 64'h203);
    drive(0, 0, 32'h0, 1);
    chk("unaligned_pc",   64'(out_pc),    64'h203);
    chk("unaligned_next", 64'(imem_addr), 64'h207);

    // Random ready/redirect traffic checked only by the scoreboard.
    for (int k = 0; k < 200; k++) begin
      drive(0, ($urandom_range(0, 15) == 0), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

Interface
REQ-001 Parameter XLEN, default 32, address and PC width.
REQ-002 Parameter ILEN, default 32, instruction width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two and at least 2.
REQ-004 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-005 The module SHALL have the following ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  branch/jump taken; flush the queue and load redirect_pc.
- redirect_pc  in  XLEN  redirect target.
- imem_addr  out  XLEN  fetch address; equals the current PC.
- imem_en  out  1  a fetch is performed this cycle.
- imem_rdata  in  ILEN  instruction read combinationally from the memory in the same cycle.
- out_valid  out  1  the queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head; a stall is out_ready=0.
- out_instr  out  ILEN  instruction at the queue head.
- out_pc  out  XLEN  PC of the queue head.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-006 The module SHALL define fire = out_valid & out_ready and fetch = ~redirect_valid & ((count < DEPTH) | fire).
REQ-007 The module SHALL drive imem_en = fetch and imem_addr = PC every cycle.
REQ-008 On fetch, the module SHALL write {PC, imem_rdata} at the tail and advance PC to PC+4, wrapping modulo 2^XLEN.
REQ-009 On fire, the module SHALL pop the head.
REQ-010 When fetch and fire occur together, count SHALL be unchanged; when the queue is full and fire=1, a push into the freed slot SHALL be accepted in the same cycle.
REQ-011 Latency: an instruction fetched in cycle N SHALL appear at the head no earlier than cycle N+1; there is no same-cycle bypass.
REQ-012 Head/tail pointers SHALL wrap modulo DEPTH; full SHALL mean count==DEPTH and empty SHALL mean count==0.
REQ-013 out_valid SHALL be (count != 0) & ~redirect_valid; redirect gates the output combinationally.
REQ-014 On a redirect_valid cycle, the module SHALL take the following actions at the next edge:
- set count to 0 and both pointers to 0;
- load PC with redirect_pc;
- perform no push and no pop.
REQ-015 Redirect SHALL take priority over fetch, fire and full/empty status.
REQ-016 The first fetch after a redirect SHALL occur in the following cycle at redirect_pc; the redirect penalty is therefore 1 fetch cycle plus 1 queue cycle.
REQ-017 When out_valid=0, out_instr SHALL be 32'h0000_0013 (NOP, addi x0,x0,0) and out_pc SHALL be 0.
REQ-018 out_instr and out_pc SHALL be held stable while out_valid=1 and out_ready=0.
REQ-019 redirect_pc SHALL be used unaligned as given; alignment checking is the producer's responsibility.

Reset
REQ-020 When rst is asserted, the module SHALL immediately (asynchronously) set PC=RESET_PC, count=0 and pointers=0.
REQ-021 While rst is asserted, outputs SHALL be out_valid=0, imem_en=0, out_instr=NOP and out_pc=0.
REQ-022 Reset asserted mid-operation SHALL discard all queued entries with no partial pop.
REQ-023 On the first edge after rst deasserts, the module SHALL fetch from RESET_PC.
REQ-024 Queue storage SHALL NOT require reset; only valid-controlling state is reset.

Structure
REQ-025 XLEN, ILEN, the NOP encoding constant and the PC increment of 4 SHALL live in the shared package pentarv_pkg.
REQ-026 Queue storage, pointers and count SHALL be a sub-module fetch_fifo (parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, count), instantiated with WIDTH = XLEN+ILEN.
REQ-027 PC logic, fetch gating and output muxing SHALL reside in the top module.

Verification
REQ-028 Reset release, RESET_PC=0, out_ready=1, memory word at address a = a+1 -> imem_addr 0,4,8,... on consecutive cycles; out_pc=0 with out_instr=1 from cycle 1; throughput 1 per cycle.
REQ-029 out_ready=0 from reset, DEPTH=4 -> four fetches at PCs 0,4,8,12; count=4; imem_en=0 afterwards; head stays pc=0.
REQ-030 Queue full, then out_ready=1 -> pop and push in the same cycle; count stays 4; PC=16 fetched.
REQ-031 count=3, redirect_valid=1 with redirect_pc=0x100 and out_ready=1 -> out_valid=0 that cycle; next cycle count=0 and imem_addr=0x100; following cycle out_pc=0x100.
REQ-032 PC=0xFFFF_FFFC fetch -> next imem_addr=0x0000_0000.
REQ-033 rst pulsed while count=2 -> out_valid=0 immediately; after release, fetch restarts at RESET_PC with no stale entry emitted.
